// File: rtl/vt52_key_encoder.sv
// VT52 keyboard-side encoder: buffers key events, expands cursor/function keys into
// ESC sequences, and feeds the UART byte by byte. Define VT52_IDENT_EN for the ESC Z reply.
module vt52_key_encoder #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   input  logic       ident_req,
   input  logic       tx_done,
   output logic       tx_send,
   output logic [6:0] tx_data,
   output logic       overflow,
   output logic       busy
);

   localparam int          AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SEND      = 2'd1;
   localparam logic [1:0] ST_WAIT_LOW  = 2'd2;
   localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

   localparam logic [6:0] ASCII_ESC = 7'h1B;

   // FIFO
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          fifo_full, fifo_empty;
   logic          push, pop;
   logic [7:0]    head_code;

   logic          overflow_q, overflow_d;

   // Sequence engine
   logic [1:0]       state_q, state_d;
   logic [2:0][6:0]  seq_q, seq_d;
   logic [1:0]       last_q, last_d;
   logic [1:0]       idx_q, idx_d;
   logic [6:0]       tx_data_q, tx_data_d;
   logic [6:0]       cur_byte;
   logic [6:0]       esc_final;
   logic             ident_pend;
   logic             load_ident;

   // NOTE: next-state logic is purely combinational with blocking '=' and a default
   // for every output first, so no latch is inferred; the flops below use only '<='.
   always_comb begin
      fifo_full  = (count_q == FULL_COUNT);
      fifo_empty = (count_q == '0);
      push       = key_valid && !fifo_full;
      head_code  = fifo_mem[rd_ptr_q];
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      // Full is judged on the registered count, so a same-cycle pop cannot rescue the key.
      overflow_d = key_valid && fifo_full;
   end

   always_comb begin
      case (head_code[2:0])
         3'd0:    esc_final = 7'h41;
         3'd1:    esc_final = 7'h42;
         3'd2:    esc_final = 7'h43;
         3'd3:    esc_final = 7'h44;
         3'd4:    esc_final = 7'h50;
         3'd5:    esc_final = 7'h51;
         default: esc_final = 7'h52;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      last_d     = last_q;
      idx_d      = idx_q;
      pop        = 1'b0;
      load_ident = 1'b0;
      case (state_q)
         ST_IDLE: begin
            idx_d = 2'd0;
            if (ident_pend) begin
               load_ident = 1'b1;
               seq_d      = {7'h4B, 7'h2F, ASCII_ESC};
               last_d     = 2'd2;
               state_d    = ST_SEND;
            end else if (!fifo_empty) begin
               pop = 1'b1;
               if (!head_code[7]) begin
                  seq_d[0] = head_code[6:0];
                  last_d   = 2'd0;
                  state_d  = ST_SEND;
               end else if (head_code[6:3] == 4'd0 && head_code[2:0] != 3'd7) begin
                  seq_d[0] = ASCII_ESC;
                  seq_d[1] = esc_final;
                  last_d   = 2'd1;
                  state_d  = ST_SEND;
               end
               // Codes 0x87..0xFF are consumed here and the engine stays idle.
            end
         end
         ST_SEND: begin
            if (tx_done) begin
               state_d = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (!tx_done) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         default: begin
            if (tx_done) begin
               if (idx_q != last_q) begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
      endcase
   end

   // tx_data shows the new byte in the strobe cycle and holds it afterwards.
   always_comb begin
      cur_byte  = seq_q[idx_q];
      tx_send   = (state_q == ST_SEND) && tx_done;
      tx_data_d = tx_send ? cur_byte : tx_data_q;
      tx_data   = tx_data_d;
      overflow  = overflow_q;
      busy      = (count_q != '0) || ident_pend || (state_q != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= ST_IDLE;
         seq_q      <= '0;
         last_q     <= 2'd0;
         idx_q      <= 2'd0;
         tx_data_q  <= 7'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         seq_q      <= seq_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // NOTE: the storage array is not reset; the pointers and count alone define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= key_code;
      end
   end

`ifdef VT52_IDENT_EN
   logic ident_q, ident_d;

   always_comb begin
      ident_d    = (ident_q && !load_ident) || ident_req;
      ident_pend = ident_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ident_q <= 1'b0;
      end else begin
         ident_q <= ident_d;
      end
   end
`else
   logic unused_ident;

   assign ident_pend   = 1'b0;
   assign unused_ident = ident_req | load_ident;
`endif

endmodule

// File: tb/tb_vt52_key_encoder.sv
// Directed bench for vt52_key_encoder: a UART stand-in drives tx_done and logs every strobe,
// a vector table covers the code map, and hand sequences cover the multi-cycle corners.
module tb_vt52_key_encoder;

   logic       clk;
   logic       reset;
   logic       key_valid;
   logic [7:0] key_code;
   logic       ident_req;
   logic       tx_done;
   logic       tx_send;
   logic [6:0] tx_data;
   logic       overflow;
   logic       busy;

   vt52_key_encoder #(.FIFO_DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .key_valid (key_valid),
      .key_code  (key_code),
      .ident_req (ident_req),
      .tx_done   (tx_done),
      .tx_send   (tx_send),
      .tx_data   (tx_data),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         viol     = 0;
   int         ovf_cnt  = 0;
   int         last_strobe_cyc = 0;
   int         uart_cnt = 0;
   logic       hold_low = 1'b0;
   logic       strobe_pending = 1'b0;
   logic       prev_send = 1'b0;
   logic       need_low  = 1'b0;
   logic [6:0] prev_data = 7'd0;
   logic [6:0] rx_q [$];
   logic [6:0] exp_q [$];

   typedef struct {
      logic [7:0] code;
      int         n;
      logic [6:0] b0;
      logic [6:0] b1;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // UART stand-in: tx_done drops the cycle after a strobe and stays low for three cycles.
   initial begin
      tx_done = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (strobe_pending) begin
            uart_cnt       = 3;
            strobe_pending = 1'b0;
         end else if (uart_cnt > 0) begin
            uart_cnt--;
         end
         tx_done = (uart_cnt == 0) && !hold_low;
      end
   end

   // Mid-cycle monitor: logs bytes and counts handshake or hold violations.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         need_low = 1'b0;
      end else begin
         if (tx_send) begin
            if (!tx_done || prev_send || need_low) viol++;
            rx_q.push_back(tx_data);
            last_strobe_cyc = cyc;
            strobe_pending  = 1'b1;
            need_low        = 1'b1;
         end else begin
            if (!tx_done) need_low = 1'b0;
            if (tx_data !== prev_data) viol++;
         end
         if (overflow) ovf_cnt++;
      end
      prev_send = tx_send;
      prev_data = tx_data;
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic pulse(input logic [7:0] c, input logic kv, input logic id);
      @(posedge clk);
      #1;
      key_valid = kv;
      key_code  = c;
      ident_req = id;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      ident_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      repeat (3) @(posedge clk);
      while (t < 500) begin
         @(negedge clk);
         if (!busy && tx_done && uart_cnt == 0) break;
         t++;
      end
      check({name, "_idle_in_time"}, 32'(t < 500), 32'd1);
   endtask

   task automatic wait_rx(input string name, input int n);
      int t;
      t = 0;
      while (rx_q.size() < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      check({name, "_rx_in_time"}, 32'(t < 500), 32'd1);
   endtask

   task automatic check_rx(input string name);
      check({name, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
      end
   endtask

   initial begin
      int c0;
      int ovf0;

      vecs[0]  = '{8'h00, 1, 7'h00, 7'h00};
      vecs[1]  = '{8'h7F, 1, 7'h7F, 7'h00};
      vecs[2]  = '{8'h41, 1, 7'h41, 7'h00};
      vecs[3]  = '{8'h80, 2, 7'h1B, 7'h41};
      vecs[4]  = '{8'h81, 2, 7'h1B, 7'h42};
      vecs[5]  = '{8'h82, 2, 7'h1B, 7'h43};
      vecs[6]  = '{8'h83, 2, 7'h1B, 7'h44};
      vecs[7]  = '{8'h84, 2, 7'h1B, 7'h50};
      vecs[8]  = '{8'h85, 2, 7'h1B, 7'h51};
      vecs[9]  = '{8'h86, 2, 7'h1B, 7'h52};
      vecs[10] = '{8'h87, 0, 7'h00, 7'h00};
      vecs[11] = '{8'hFF, 0, 7'h00, 7'h00};

      reset     = 1'b1;
      key_valid = 1'b0;
      key_code  = 8'h00;
      ident_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx_send",  32'(tx_send),  32'd0);
      check("reset_tx_data",  32'(tx_data),  32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_busy",     32'(busy),     32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Single ASCII key: strobe two cycles after the key strobe.
      rx_q.delete();
      @(posedge clk);
      #1;
      c0        = cyc;
      key_valid = 1'b1;
      key_code  = 8'h61;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      wait_idle("key61");
      exp_q = '{7'h61};
      check_rx("key61");
      check("key61_latency", 32'(last_strobe_cyc - c0), 32'd2);

      for (int i = 0; i < 12; i++) begin
         rx_q.delete();
         pulse(vecs[i].code, 1'b1, 1'b0);
         wait_idle($sformatf("vec%0d", i));
         check($sformatf("vec%0d_count", i), rx_q.size(), vecs[i].n);
         if (vecs[i].n >= 1 && rx_q.size() >= 1)
            check($sformatf("vec%0d_b0", i), 32'(rx_q[0]), 32'(vecs[i].b0));
         if (vecs[i].n == 2 && rx_q.size() >= 2)
            check($sformatf("vec%0d_b1", i), 32'(rx_q[1]), 32'(vecs[i].b1));
      end

      // Two identify requests during an in-flight ESC A merge into one reply.
      rx_q.delete();
      pulse(8'h80, 1'b1, 1'b0);
      wait_rx("ident", 1);
      pulse(8'h00, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      pulse(8'h00, 1'b0, 1'b1);
      wait_idle("ident");
`ifdef VT52_IDENT_EN
      exp_q = '{7'h1B, 7'h41, 7'h1B, 7'h2F, 7'h4B};
`else
      exp_q = '{7'h1B, 7'h41};
`endif
      check_rx("ident");

      // Key and identify in the same idle cycle: reply first, then the key.
      rx_q.delete();
      pulse(8'h5A, 1'b1, 1'b1);
      wait_idle("both");
`ifdef VT52_IDENT_EN
      exp_q = '{7'h1B, 7'h2F, 7'h4B, 7'h5A};
`else
      exp_q = '{7'h5A};
`endif
      check_rx("both");

      // UART stalled: the first key is taken straight into the sequence engine, the next
      // eight fill the FIFO, and the tenth is the one dropped.
      rx_q.delete();
      @(posedge clk);
      #1;
      hold_low = 1'b1;
      repeat (3) @(posedge clk);
      ovf0 = ovf_cnt;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         key_valid = 1'b1;
         key_code  = 8'h30 + 8'(i);
      end
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
      check("ovf_busy",   32'(busy),           32'd1);
      check("ovf_nothing_sent", rx_q.size(),   32'd0);
      hold_low = 1'b0;
      wait_idle("ovf");
      exp_q = '{7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 7'h37, 7'h38};
      check_rx("ovf");

      // Silent code followed by a printable key.
      rx_q.delete();
      pulse(8'h90, 1'b1, 1'b0);
      pulse(8'h41, 1'b1, 1'b0);
      wait_idle("silent");
      exp_q = '{7'h41};
      check_rx("silent");
      check("silent_busy_low", 32'(busy), 32'd0);

      // Reset between the two bytes of ESC D.
      rx_q.delete();
      pulse(8'h83, 1'b1, 1'b0);
      wait_rx("rst", 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", rx_q.size(), 32'd1);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      rx_q.delete();
      pulse(8'h42, 1'b1, 1'b0);
      wait_idle("rst_after");
      exp_q = '{7'h42};
      check_rx("rst_after");

      check("protocol_violations", viol, 32'd0);
      check("overflow_total", ovf_cnt, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
